// File: rtl/expr_arbiter.sv
// Round-robin arbiter sharing one non-pipelined expr core between two requesters.
// It holds the operand for LATENCY cycles, then returns the captured result on the winner's channel.
module expr_arbiter #(
  parameter int LATENCY = 56,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  input  logic        resp0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  input  logic        resp1_ready,
  output logic [31:0] core_x,
  input  logic [31:0] core_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t      state, state_next;
  logic        gnt, gnt_next;
  logic        prio, prio_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0] core_x_next;
  logic [31:0] resp_data, resp_data_next;
  logic        any_req;
  logic        win;
  logic        owner_ready;

  // Requester 1 wins when it is alone, or on a tie when it holds priority.
  assign any_req     = req0_valid | req1_valid;
  assign win         = (req0_valid && req1_valid) ? prio : req1_valid;
  assign owner_ready = gnt ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      cnt       <= '0;
      core_x    <= '0;
      resp_data <= '0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      prio      <= prio_next;
      cnt       <= cnt_next;
      core_x    <= core_x_next;
      resp_data <= resp_data_next;
    end
  end

  always_comb begin
    state_next     = state;
    gnt_next       = gnt;
    prio_next      = prio;
    cnt_next       = cnt;
    core_x_next    = core_x;
    resp_data_next = resp_data;
    // Ready is gated by reset so every output reads 0 while reset is held.
    req0_ready     = reset && (state == IDLE) && any_req && !win;
    req1_ready     = reset && (state == IDLE) && any_req && win;
    resp0_valid    = (state == RESP) && !gnt;
    resp1_valid    = (state == RESP) && gnt;
    resp0_data     = resp_data;
    resp1_data     = resp_data;
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next  = BUSY;
          gnt_next    = win;
          cnt_next    = '0;
          core_x_next = win ? req1_x : req0_x;
        end
      end
      BUSY: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          resp_data_next = core_result;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (owner_ready) begin
          state_next = IDLE;
          prio_next  = ~gnt;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_expr_arbiter.sv
// Directed bench for expr_arbiter with a delay-line core model (result = operand + 1).
module tb_expr_arbiter;
  localparam int LATENCY = 56;
  localparam int CNT_W   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_x, req1_x;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic [31:0] core_x, core_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Core model: result is valid LATENCY cycles after the operand changes.
  logic [31:0] pipe [LATENCY-1];
  always @(posedge clk) begin
    pipe[0] <= core_x + 32'h1;
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_result = pipe[LATENCY-2];

  expr_arbiter #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .core_x(core_x), .core_result(core_result), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req0_x = 32'h1234; req1_valid = 1'b1; req1_x = 32'h5678;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
    end
    tick();
    checks++;
    if ({core_x, resp0_data, resp1_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: core_x=%h r0=%h r1=%h expected 0", core_x, resp0_data, resp1_data);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    req0_x = 32'h3F800000; req0_valid = 1'b1; resp0_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({busy, core_x} !== {1'b1, 32'h3F800000}) begin
      errors++; $display("FAIL single_accept: busy=%b core_x=%h expected 1 3f800000", busy, core_x);
    end
    for (int c = 1; c <= 57; c++) begin
      tick();
      if (c < LATENCY) begin
        checks++;
        if ({resp0_valid, core_x} !== {1'b0, 32'h3F800000}) begin
          errors++; $display("FAIL single_hold c=%0d: valid=%b core_x=%h expected 0 3f800000", c, resp0_valid, core_x);
        end
      end else if (c == LATENCY) begin
        checks++;
        if ({resp0_valid, resp0_data} !== {1'b1, 32'h3F800001}) begin
          errors++; $display("FAIL single_resp: valid=%b data=%h expected 1 3f800001", resp0_valid, resp0_data);
        end
      end else begin
        checks++;
        if ({resp0_valid, busy} !== 2'b00) begin
          errors++; $display("FAIL single_done: valid=%b busy=%b expected 0 0", resp0_valid, busy);
        end
      end
    end
  endtask

  task automatic test_tie();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0_x = 32'h10; req1_x = 32'h20; req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL tie_grant0: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    for (int c = 1; c <= 58; c++) begin
      tick();
      if (c <= 57) begin
        checks++;
        if (resp1_valid !== 1'b0) begin
          errors++; $display("FAIL tie_resp1_quiet c=%0d: got %b expected 0", c, resp1_valid);
        end
      end
      if (c == LATENCY) begin
        checks++;
        if ({resp0_valid, resp0_data} !== {1'b1, 32'h11}) begin
          errors++; $display("FAIL tie_resp0: valid=%b data=%h expected 1 00000011", resp0_valid, resp0_data);
        end
      end
      if (c == 57) begin
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
          errors++; $display("FAIL tie_grant1: got %b expected 10", {req1_ready, req0_ready});
        end
      end
      if (c == 58) begin
        req1_valid = 1'b0;
        checks++;
        if ({busy, core_x} !== {1'b1, 32'h20}) begin
          errors++; $display("FAIL tie_accept1: busy=%b core_x=%h expected 1 00000020", busy, core_x);
        end
      end
    end
    for (int c = 1; c <= 57; c++) begin
      tick();
      if (c == LATENCY) begin
        checks++;
        if ({resp1_valid, resp0_valid, resp1_data} !== {2'b10, 32'h21}) begin
          errors++; $display("FAIL tie_resp1: v1=%b v0=%b data=%h expected 1 0 00000021", resp1_valid, resp0_valid, resp1_data);
        end
      end
      if (c == 57) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL tie_done: busy=%b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    resp1_ready = 1'b0; resp0_ready = 1'b0;
    req1_x = 32'hABCD0000; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    checks++;
    if (core_x !== 32'hABCD0000) begin
      errors++; $display("FAIL bp_accept: core_x=%h expected abcd0000", core_x);
    end
    for (int c = 1; c <= LATENCY; c++) tick();
    checks++;
    if ({resp1_valid, resp1_data} !== {1'b1, 32'hABCD0001}) begin
      errors++; $display("FAIL bp_resp: valid=%b data=%h expected 1 abcd0001", resp1_valid, resp1_data);
    end
    req0_x = 32'h99; req0_valid = 1'b1; resp0_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if ({resp1_valid, resp1_data, req0_ready, busy, resp0_valid} !== {1'b1, 32'hABCD0001, 3'b010}) begin
        errors++; $display("FAIL bp_hold c=%0d: v1=%b d1=%h rdy0=%b busy=%b v0=%b expected 1 abcd0001 0 1 0",
                           c, resp1_valid, resp1_data, req0_ready, busy, resp0_valid);
      end
    end
    req0_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b1;
    tick();
    checks++;
    if ({resp1_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL bp_release: valid=%b busy=%b expected 0 0", resp1_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3];
    xs[0] = 32'h100; xs[1] = 32'h200; xs[2] = 32'h300;
    resp1_ready = 1'b1;
    req1_x = xs[0]; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_first_ready: got %b expected 10", {req1_ready, req0_ready});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({busy, core_x} !== {1'b1, xs[k]}) begin
        errors++; $display("FAIL b2b_accept k=%0d: busy=%b core_x=%h expected 1 %h", k, busy, core_x, xs[k]);
      end
      if (k < 2) req1_x = xs[k+1];
      else req1_valid = 1'b0;
      for (int c = 1; c <= 57; c++) begin
        tick();
        if (c == LATENCY) begin
          checks++;
          if ({resp1_valid, resp1_data, req1_ready} !== {1'b1, xs[k] + 32'h1, 1'b0}) begin
            errors++; $display("FAIL b2b_resp k=%0d: valid=%b data=%h rdy=%b expected 1 %h 0",
                               k, resp1_valid, resp1_data, req1_ready, xs[k] + 32'h1);
          end
        end
        if (c == 57) begin
          checks++;
          if ({req1_ready, busy} !== {(k < 2), 1'b0}) begin
            errors++; $display("FAIL b2b_next k=%0d: rdy=%b busy=%b expected %b 0", k, req1_ready, busy, (k < 2));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    resp0_ready = 1'b1;
    req0_x = 32'h77; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    for (int c = 1; c <= 20; c++) tick();
    req0_x = 32'h5; req0_valid = 1'b1;
    reset = 1'b0;
    #2;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp0_data, resp1_data, core_x} !== 101'h0) begin
      errors++; $display("FAIL midrst_outputs: rdy=%b%b v=%b%b busy=%b d0=%h d1=%h core_x=%h expected all 0",
                         req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp0_data, resp1_data, core_x);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (core_x !== 32'h5) begin
      errors++; $display("FAIL midrst_accept: core_x=%h expected 00000005", core_x);
    end
    for (int c = 1; c <= 57; c++) begin
      tick();
      if (c < LATENCY) begin
        checks++;
        if ({resp0_valid, resp1_valid} !== 2'b00) begin
          errors++; $display("FAIL midrst_stale c=%0d: v0=%b v1=%b expected 0 0", c, resp0_valid, resp1_valid);
        end
      end else if (c == LATENCY) begin
        checks++;
        if ({resp0_valid, resp0_data} !== {1'b1, 32'h6}) begin
          errors++; $display("FAIL midrst_resp: valid=%b data=%h expected 1 00000006", resp0_valid, resp0_data);
        end
      end else begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL midrst_done: busy=%b expected 0", busy);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_x = '0; req1_x = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
